// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder: FSM states, one-hot line
// events and the ACK level.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_SUB_ADDR,
    ST_SUB_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } sccb_state_t;

  typedef enum logic [3:0] {
    EV_NONE  = 4'b0000,
    EV_START = 4'b0001,
    EV_STOP  = 4'b0010,
    EV_RISE  = 4'b0100,
    EV_FALL  = 4'b1000
  } sccb_event_t;

  localparam logic ACK_LEVEL = 1'b0;

endpackage

// File: rtl/sccb_line_filter.sv
// SIOC/SIOD conditioning: 2-flop synchronizer, FILTER_LEN-sample glitch filter
// and a single one-hot bus event per clock derived from the filtered lines.
module sccb_line_filter
  import sccb_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sioc_in,
  input  logic        siod_in,
  output logic        siod_filt,
  output sccb_event_t ev
);

  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

  // Index 0 = SIOC, index 1 = SIOD.
  logic [1:0] w_raw;
  logic [1:0] r_sync0;
  logic [1:0] r_sync1;
  logic [1:0] r_filt;
  logic [1:0] r_prev;
  logic [3:0] r_cnt [2];

  assign w_raw = {siod_in, sioc_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= '1;
      r_sync1 <= '1;
      r_filt  <= '1;
      r_prev  <= '1;
      for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
      r_prev  <= r_filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LAST) begin
          r_filt[i] <= r_sync1[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // SIOD transitions with SIOC high win over a coincident SIOC edge.
  always_comb begin
    ev = EV_NONE;
    if (r_filt[0] && r_prev[1] && !r_filt[1])
      ev = EV_START;
    else if (r_filt[0] && !r_prev[1] && r_filt[1])
      ev = EV_STOP;
    else if (!r_prev[0] && r_filt[0])
      ev = EV_RISE;
    else if (r_prev[0] && !r_filt[0])
      ev = EV_FALL;
  end

  assign siod_filt = r_filt[1];

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes 3-phase writes and 2-phase reads into an 8-bit register
// port. Define SCCB_AUTOINC_EN for burst writes/reads with pointer autoincrement.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_drive_low,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic ACK_DRIVE = !ACK_LEVEL;

  logic        w_siod;
  sccb_event_t w_ev;
  logic [7:0]  w_byte;

  sccb_state_t r_state;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_rw;
  logic        r_drive;
  logic [7:0]  r_reg_addr;
  logic [7:0]  r_reg_wdata;
  logic        r_reg_we;
  logic        r_busy;
`ifdef SCCB_AUTOINC_EN
  logic        r_nack;
`endif

  sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .sioc_in   (sioc_in),
    .siod_in   (siod_in),
    .siod_filt (w_siod),
    .ev        (w_ev)
  );

  assign w_byte = {r_shift[6:0], w_siod};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_drive     <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SCCB_AUTOINC_EN
      r_nack      <= 1'b1;
`endif
    end else begin
      r_reg_we <= 1'b0;
      if (w_ev == EV_STOP) begin
        r_state  <= ST_IDLE;
        r_drive  <= 1'b0;
        r_busy   <= 1'b0;
        r_bitcnt <= '0;
      end else if (w_ev == EV_START) begin
        r_state  <= ST_DEV_ADDR;
        r_drive  <= 1'b0;
        r_bitcnt <= '0;
      end else begin
        case (r_state)
          // The three master-to-responder byte phases share one shifter.
          ST_DEV_ADDR, ST_SUB_ADDR, ST_WR_DATA: begin
            if (w_ev == EV_RISE && r_bitcnt != 4'd8) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                if (r_state == ST_SUB_ADDR) r_reg_addr <= w_byte;
                if (r_state == ST_WR_DATA) begin
                  r_reg_wdata <= w_byte;
                  r_reg_we    <= 1'b1;
                end
              end
            end else if (w_ev == EV_FALL && r_bitcnt == 4'd8) begin
              r_bitcnt <= '0;
              if (r_state == ST_DEV_ADDR) begin
                if (r_shift[7:1] == DEV_ADDR[7:1]) begin
                  r_state <= ST_DEV_ACK;
                  r_drive <= ACK_DRIVE;
                  r_busy  <= 1'b1;
                  r_rw    <= r_shift[0];
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end else begin
                r_state <= (r_state == ST_SUB_ADDR) ? ST_SUB_ACK : ST_WR_ACK;
                r_drive <= ACK_DRIVE;
              end
            end
          end
          ST_DEV_ACK: begin
            if (w_ev == EV_FALL) begin
              r_bitcnt <= '0;
              if (r_rw) begin
                r_state <= ST_RD_DATA;
                r_shift <= reg_rdata;
                r_drive <= ~reg_rdata[7];
              end else begin
                r_state <= ST_SUB_ADDR;
                r_drive <= 1'b0;
              end
            end
          end
          ST_SUB_ACK: begin
            if (w_ev == EV_FALL) begin
              r_state <= ST_WR_DATA;
              r_drive <= 1'b0;
            end
          end
          ST_WR_ACK: begin
            if (w_ev == EV_FALL) begin
              r_drive <= 1'b0;
`ifdef SCCB_AUTOINC_EN
              r_state    <= ST_WR_DATA;
              r_bitcnt   <= '0;
              r_reg_addr <= r_reg_addr + 8'd1;
`else
              r_state <= ST_WAIT_STOP;
`endif
            end
          end
          ST_RD_DATA: begin
            if (w_ev == EV_RISE && r_bitcnt != 4'd8) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_ev == EV_FALL) begin
              if (r_bitcnt == 4'd8) begin
                r_state  <= ST_RD_ACK;
                r_drive  <= 1'b0;
                r_bitcnt <= '0;
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_drive <= ~r_shift[6];
              end
            end
          end
          ST_RD_ACK: begin
`ifdef SCCB_AUTOINC_EN
            // Pointer moves at the ACK rise so reg_rdata has settled by the FALL.
            if (w_ev == EV_RISE) begin
              r_nack <= w_siod;
              if (w_siod == ACK_LEVEL) r_reg_addr <= r_reg_addr + 8'd1;
            end else if (w_ev == EV_FALL) begin
              if (r_nack != ACK_LEVEL) begin
                r_state <= ST_WAIT_STOP;
              end else begin
                r_state  <= ST_RD_DATA;
                r_shift  <= reg_rdata;
                r_drive  <= ~reg_rdata[7];
                r_bitcnt <= '0;
              end
            end
`else
            if (w_ev == EV_FALL) r_state <= ST_WAIT_STOP;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign siod_drive_low = r_drive;
  assign reg_addr       = r_reg_addr;
  assign reg_wdata      = r_reg_wdata;
  assign reg_we         = r_reg_we;
  assign busy           = r_busy;

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: a bit-banged SCCB master plus a
// transaction-level model of acks, register writes, read data and the pointer.
module tb_sccb_responder;

  localparam int unsigned Q = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       glitch = 1'b0;
  logic       sioc_in, siod_in, siod_drive_low, reg_we, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  logic [7:0]  bank [256];
  bit          wr_flag [256];
  logic [7:0]  exp_bank [256];
  logic [7:0]  m_ptr;
  logic [15:0] we_log [$];
  int unsigned drv_cnt = 0;
  int unsigned busy_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  tx [8];

  always #20 clk = ~clk;

  assign sioc_in   = m_scl ^ glitch;
  assign siod_in   = m_sda & ~siod_drive_low;
  assign reg_rdata = wr_flag[reg_addr] ? bank[reg_addr] : (reg_addr ^ 8'h7C);

  sccb_responder #(.DEV_ADDR(8'h42), .FILTER_LEN(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .sioc_in        (sioc_in),
    .siod_in        (siod_in),
    .siod_drive_low (siod_drive_low),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_we         (reg_we),
    .reg_rdata      (reg_rdata),
    .busy           (busy)
  );

  // External register bank and activity monitor.
  always @(negedge clk) begin
    if (reg_we) begin
      we_log.push_back({reg_addr, reg_wdata});
      bank[reg_addr] <= reg_wdata;
      wr_flag[reg_addr] <= 1'b1;
    end
    if (siod_drive_low) drv_cnt <= drv_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic pulse_glitch();
    glitch = 1'b1; wait_clk(1);
    glitch = 1'b0;
  endtask

  // One SCL period; samples the wired-AND line and the responder drive mid-high.
  task automatic bus_bit(input logic b, input logic glitchy, output logic s, output logic dr);
    m_sda = b; wait_clk(Q / 2);
    if (glitchy) pulse_glitch();
    wait_clk(Q / 2);
    m_scl = 1'b1; wait_clk(Q / 2);
    s = siod_in;
    dr = siod_drive_low;
    if (glitchy) pulse_glitch();
    wait_clk(Q / 2);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic glitchy, output logic ack);
    logic s, dr;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], glitchy, s, dr);
    bus_bit(1'b1, 1'b0, s, dr);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d, output logic dr9);
    logic s, dr;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s, dr);
      d[i] = s;
    end
    bus_bit(nack, 1'b0, s, dr9);
  endtask

  task automatic run_write(input int unsigned n, input logic glitchy);
    logic        match, ack, exp_ack;
    logic [15:0] exp_we [$];
    int unsigned base, d0, b0;
    match = (tx[0][7:1] == 7'h21) && !tx[0][0];
    base = we_log.size();
    d0 = drv_cnt;
    b0 = busy_cnt;
    bus_start();
    for (int unsigned i = 0; i < n; i++) begin
      send_byte(tx[i], glitchy, ack);
      exp_ack = 1'b0;
      if (match) begin
        if (i <= 1) exp_ack = 1'b1;
        if (i == 1) m_ptr = tx[1];
`ifdef SCCB_AUTOINC_EN
        if (i >= 2) begin
          exp_ack = 1'b1;
          exp_we.push_back({m_ptr, tx[i]});
          exp_bank[m_ptr] = tx[i];
          m_ptr = m_ptr + 8'd1;
        end
`else
        if (i == 2) begin
          exp_ack = 1'b1;
          exp_we.push_back({m_ptr, tx[i]});
          exp_bank[m_ptr] = tx[i];
        end
`endif
      end
      chk($sformatf("wr_ack%0d", i), 32'(ack), 32'(exp_ack));
    end
    chk("busy_in_tx", 32'(busy), 32'(match));
    bus_stop();
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("we_count", 32'(we_log.size() - base), 32'(exp_we.size()));
    for (int unsigned k = 0; k < exp_we.size() && base + k < we_log.size(); k++)
      chk($sformatf("we%0d", k), 32'(we_log[base + k]), 32'(exp_we[k]));
    chk("ptr_after_wr", 32'(reg_addr), 32'(m_ptr));
    if (!match) begin
      chk("no_drive", 32'(drv_cnt - d0), 32'd0);
      chk("no_busy", 32'(busy_cnt - b0), 32'd0);
    end
  endtask

  task automatic run_read(input int unsigned n);
    logic        match, ack, dr9;
    logic [7:0]  d, exp_d;
    int unsigned base;
    match = (tx[0][7:1] == 7'h21);
    base = we_log.size();
    bus_start();
    send_byte(tx[0], 1'b0, ack);
    chk("rd_dev_ack", 32'(ack), 32'(match));
    for (int unsigned i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d, dr9);
      exp_d = 8'hFF;
      if (match) begin
`ifdef SCCB_AUTOINC_EN
        exp_d = exp_bank[m_ptr];
        if (i != n - 1) m_ptr = m_ptr + 8'd1;
`else
        if (i == 0) exp_d = exp_bank[m_ptr];
`endif
      end
      chk($sformatf("rd_data%0d", i), 32'(d), 32'(exp_d));
      chk($sformatf("rd_release9_%0d", i), 32'(dr9), 32'd0);
    end
    bus_stop();
    chk("rd_no_we", 32'(we_log.size() - base), 32'd0);
    chk("ptr_after_rd", 32'(reg_addr), 32'(m_ptr));
  endtask

  initial begin
    #50ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic        a, s, dr;
    logic [7:0]  r8;
    int unsigned base, n;
    for (int i = 0; i < 256; i++) exp_bank[i] = 8'(i) ^ 8'h7C;
    m_ptr = '0;

    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    chk("rst_drive", 32'(siod_drive_low), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_we", 32'(reg_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    tx[0] = 8'h42; tx[1] = 8'h12; tx[2] = 8'h80;
    run_write(3, 1'b0);

    tx[0] = 8'h42; tx[1] = 8'h0A;
    run_write(2, 1'b0);
    tx[0] = 8'h43;
    run_read(1);

    tx[0] = 8'h60; tx[1] = 8'h12; tx[2] = 8'h34;
    run_write(3, 1'b0);

    tx[0] = 8'h42; tx[1] = 8'h33; tx[2] = 8'hA5;
    run_write(3, 1'b1);

    // Abort after 5 data bits.
    base = we_log.size();
    bus_start();
    send_byte(8'h42, 1'b0, a); chk("abort_ack0", 32'(a), 32'd1);
    send_byte(8'h05, 1'b0, a); chk("abort_ack1", 32'(a), 32'd1);
    m_ptr = 8'h05;
    for (int i = 0; i < 5; i++) bus_bit(1'b0, 1'b0, s, dr);
    bus_stop();
    chk("abort_no_we", 32'(we_log.size() - base), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ptr", 32'(reg_addr), 32'(m_ptr));

    // Reset while the device-address ACK is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(i == 6 || i == 1, 1'b0, s, dr);
    m_sda = 1'b1;
    wait_clk(Q / 2);
    chk("ack_before_rst", 32'(siod_drive_low), 32'd1);
    rst = 1'b1;
    wait_clk(1);
    chk("rst_mid_release", 32'(siod_drive_low), 32'd0);
    chk("rst_mid_addr", 32'(reg_addr), 32'd0);
    rst = 1'b0;
    m_ptr = '0;
    wait_clk(Q);
    bus_stop();
    chk("rst_mid_busy", 32'(busy), 32'd0);

    // Repeated start three bits into the sub-address.
    bus_start();
    send_byte(8'h42, 1'b0, a); chk("rs_ack0", 32'(a), 32'd1);
    for (int i = 0; i < 3; i++) bus_bit(i[0], 1'b0, s, dr);
    tx[0] = 8'h42; tx[1] = 8'h21; tx[2] = 8'h9C;
    run_write(3, 1'b0);

    // Burst with pointer wrap; only the first data byte lands without autoinc.
    tx[0] = 8'h42; tx[1] = 8'hFF; tx[2] = 8'h11; tx[3] = 8'h22;
    run_write(4, 1'b0);
    tx[0] = 8'h42; tx[1] = 8'hFE;
    run_write(2, 1'b0);
    tx[0] = 8'h43;
    run_read(3);

    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          n = $urandom_range(1, 4);
          tx[0] = 8'h42;
          for (int i = 1; i < 4; i++) tx[i] = 8'($urandom);
          run_write(n, 1'($urandom_range(0, 1)));
        end
        2: begin
          tx[0] = 8'h42; tx[1] = 8'($urandom);
          run_write(2, 1'b0);
          tx[0] = 8'h43;
          run_read($urandom_range(1, 3));
        end
        default: begin
          do r8 = 8'($urandom); while (r8[7:1] == 7'h21);
          tx[0] = r8;
          for (int i = 1; i < 3; i++) tx[i] = 8'($urandom);
          if (r8[0]) run_read(1);
          else run_write(3, 1'b0);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB target (camera-side responder) for the existing SCCB master's protocol; used as an OV7670 register model in the camera-path testbench and as an on-chip configuration port.
- Oversamples SIOC/SIOD on the system clock, detects start/stop, matches the device address and decodes 3-phase writes and 2-phase reads.
- Exposes an 8-bit register write/read interface to an external register bank.

Parameters:
- DEV_ADDR, 8'h42, 8-bit write address; bit 0 ignored for match, read address is DEV_ADDR|1.
- FILTER_LEN, 3, consecutive equal samples (clk cycles) needed to accept a line change; legal range 1..15.

Ports:
- clk  input  1  system clock (25 MHz nominal, at least 16x SIOC)
- rst  input  1  synchronous, active-high reset
- sioc_in  input  1  raw SIOC from pad (asynchronous)
- siod_in  input  1  raw SIOD from pad (asynchronous)
- siod_drive_low  output  1  1 = pull SIOD low; the top level ties the pad to 0 when set, else 'z
- reg_addr  output  8  register pointer
- reg_wdata  output  8  write data, valid with reg_we
- reg_we  output  1  one-clk write strobe
- reg_rdata  input  8  read data for reg_addr; combinational or at most 2-clk latency
- busy  output  1  high from accepted start with address match until stop

Behaviour:
- Reset values: siod_drive_low=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, FSM=IDLE, bit counter=0.
- Line conditioning: 2-flop synchronizer, then filter. Filtered value changes only after FILTER_LEN identical samples.
- Events, from the filtered lines, at most one per clk:
  - START: SIOD falls while SIOC high.
  - STOP: SIOD rises while SIOC high.
  - RISE/FALL: SIOC edges.
- Bit sampling: SIOD is sampled on RISE.
- Bit driving: responder-driven bits change only on FALL, so SIOD is stable while SIOC is high.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE -> DEV_ADDR on START.
- DEV_ADDR, after 8 RISEs, at the next FALL:
  - bits[7:1]==DEV_ADDR[7:1]: enter DEV_ACK and drive low; set busy.
  - mismatch: enter WAIT_STOP with no drive.
- DEV_ACK, at the FALL ending the 9th bit: release; go to SUB_ADDR (R/W=0) or RD_DATA (R/W=1).
  - For RD_DATA: on that same FALL, capture reg_rdata into the shift register and present bit 7.
  - reg_addr has been stable at least one full SIOC half-period before this point.
- SUB_ADDR: 8 bits are loaded into reg_addr at the 8th RISE. SUB_ACK drives the ACK, then goes to WR_DATA.
- WR_DATA: at the 8th RISE, reg_wdata is set and reg_we pulses for 1 clk with the current reg_addr. WR_ACK then ACKs.
- After WR_ACK:
  - SCCB_AUTOINC_EN absent: WAIT_STOP. Further bytes get no ACK and no write.
  - SCCB_AUTOINC_EN defined: see Optional Feature.
- RD_DATA: shifts MSB first on each FALL. The line is released after the FALL ending bit 0.
- RD_ACK: master bit sampled on RISE.
  - 1 (NA): WAIT_STOP.
  - 0: WAIT_STOP without autoinc; next byte with autoinc.
- Responder never drives during the 9th bit of a read byte.
- Pointer semantics: reg_addr persists across transactions. A 2-phase read is dev+sub then stop, followed by dev|1 returning the byte at reg_addr.
- STOP in any state: IDLE, release SIOD, busy=0, reg_addr retained.
- START in any non-IDLE state (repeated start): DEV_ADDR, release SIOD, bit counter=0, reg_addr retained.
- START/STOP override a same-cycle edge; at most one event fires per clk by construction.
- rst mid-transfer: immediate release of SIOD on the next clk. reg_addr returns to 0.
- A partial byte before STOP produces no reg_we.

Optional Feature:
- Macro: SCCB_AUTOINC_EN.
- Defined, write path: after WR_ACK, reg_addr increments (0xFF wraps to 0x00) and the FSM returns to WR_DATA for burst writes.
- Defined, read path: after a master ACK in RD_ACK, reg_addr increments and the next byte is fetched at the FALL.
- Absent: single data byte per transaction; reg_addr only changes in SUB_ADDR.

Decomposition:
- Package sccb_pkg: FSM state localparams (4-bit), event codes (EV_NONE, EV_START, EV_STOP, EV_RISE, EV_FALL), and the ACK level constant.
- Sub-module sccb_line_filter: synchronizer, glitch filter and edge/event detector for the SIOC/SIOD pair. It outputs the filtered siod and a one-hot event.
- The FSM, shift register and counters stay in sccb_responder.

Test Plan:
- Write 0x42, 0x12, 0x80 at 100 kHz -> one reg_we with reg_addr=0x12, reg_wdata=0x80; ACK low on all three 9th bits; busy drops after stop.
- Write 0x42, 0x0A, stop; then 0x43 with reg_rdata=0x76 and master NA -> SIOD bits 0,1,1,1,0,1,1,0 on SIOC high; released at 9th bit; no reg_we.
- Address 0x60 -> siod_drive_low never asserts, busy stays 0, no reg_we until the next start.
- 1-clk glitches on SIOC during data with FILTER_LEN=3 -> no extra bit; byte decoded as sent. Abort after 5 bits of the data byte with STOP -> no reg_we, IDLE.
- rst asserted while driving an ACK low -> siod_drive_low=0 the next clk, reg_addr=0. Repeated start mid-SUB_ADDR -> decodes the new device byte correctly.
- SCCB_AUTOINC_EN: write 0x42, 0xFF, 0x11, 0x22 -> writes 0xFF=0x11 then 0x00=0x22. Without the macro: only the first write, and the 4th byte gets no ACK.
